rvc_mem_wrap_ws: RTL and testbench

Parametrised successor of the core memory wrapper, with behavioural byte-array I_MEM and D_MEM.
- Adds configurable memory sizes, a D_MEM base address and a programmable wait-state count.
- Adds a request/ready handshake with a stall output to the pipeline.
- Adds size-based load/store steering with sign/zero extension, and misalignment/out-of-range fault reporting.
- Sits between the pipeline's fetch/memory stages and the memory arrays.

---
 rtl/rvc_mem_wrap_ws_pkg.sv | 28 ++
 rtl/rvc_mem_wrap_ws_if.sv | 23 ++
 rtl/rvc_mem_wrap_ws_align.sv | 45 ++++
 rtl/rvc_mem_wrap_ws.sv | 186 ++++++++++++++++++
 tb/tb_rvc_mem_wrap_ws.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rvc_mem_wrap_ws_pkg.sv
// Shared types and constants for the memory wrapper with wait states:
// access sizes, data-port FSM states and the reset/NOP instruction.
package rvc_mem_wrap_ws_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } t_mem_size;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } t_dmem_state;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Offset of the last byte touched by an access; size 3 is treated as word.
  function automatic logic [1:0] size_last_ofs(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rvc_mem_wrap_ws_if.sv
// Data-port handshake between the pipeline memory stage and the wrapper.
interface rvc_mem_wrap_ws_if;
  logic        DReq;
  logic        DWrEn;
  logic [1:0]  DSize;
  logic        DSignExt;
  logic [31:0] DAddr;
  logic [31:0] DWrData;
  logic [31:0] DRdData;
  logic        DReady;
  logic        DFault;
  logic        DStall;

  modport master (
    output DReq, DWrEn, DSize, DSignExt, DAddr, DWrData,
    input  DRdData, DReady, DFault, DStall
  );

  modport slave (
    input  DReq, DWrEn, DSize, DSignExt, DAddr, DWrData,
    output DRdData, DReady, DFault, DStall
  );
endinterface

// File: rtl/rvc_mem_wrap_ws_align.sv
// Combinational size steering: store byte enables, alignment/size checks,
// and load-side masking with sign/zero extension.
module rvc_mem_wrap_ws_align
  import rvc_mem_wrap_ws_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] rd_raw,
  output logic [3:0]  byte_en,
  output logic [1:0]  last_ofs,
  output logic        size_err,
  output logic        misalign,
  output logic [31:0] rd_ext
);

  t_mem_size sz;

  always_comb begin
    sz       = t_mem_size'(size);
    last_ofs = size_last_ofs(size);
    size_err = (size == 2'd3);
    misalign = 1'b0;
    byte_en  = 4'b0000;
    rd_ext   = '0;
    case (sz)
      BYTE: begin
        byte_en = 4'b0001;
        rd_ext  = {{24{sign_ext & rd_raw[7]}}, rd_raw[7:0]};
      end
      HALF: begin
        byte_en  = 4'b0011;
        misalign = addr_lo[0];
        rd_ext   = {{16{sign_ext & rd_raw[15]}}, rd_raw[15:0]};
      end
      WORD: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
        rd_ext   = rd_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_mem_wrap_ws.sv
// Core memory wrapper: registered instruction fetch from I_MEM and a
// request/ready data port to D_MEM with programmable wait states and faults.
module rvc_mem_wrap_ws
  import rvc_mem_wrap_ws_pkg::*;
#(
  parameter int unsigned I_MEM_BYTES = 4096,
  parameter int unsigned D_MEM_BYTES = 4096,
  parameter int unsigned D_MEM_BASE  = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RST_INSTR   = NOP_INSTR
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic [31:0]      Pc,
  input  logic             FetchEn,
  output logic [31:0]      InstructionQ101H,
  rvc_mem_wrap_ws_if.slave dbus
);

  localparam int unsigned IAW = $clog2(I_MEM_BYTES);
  localparam int unsigned DAW = $clog2(D_MEM_BYTES);

  logic [7:0] imem [I_MEM_BYTES] = '{default: 8'h00};
  logic [7:0] dmem [D_MEM_BYTES];

  // ---------------- fetch ----------------
  logic [31:0]    instr_d, instr_q;
  logic [IAW-1:0] iidx;
  logic [32:0]    pc_last;

  always_comb begin
    iidx    = Pc[IAW-1:0];
    pc_last = {1'b0, Pc} + 33'd3;
    instr_d = instr_q;
    if (FetchEn) begin
      if (Pc[1:0] != 2'b00 || pc_last >= 33'(I_MEM_BYTES))
        instr_d = RST_INSTR;
      else
        instr_d = {imem[iidx + IAW'(3)], imem[iidx + IAW'(2)],
                   imem[iidx + IAW'(1)], imem[iidx]};
    end
  end

  assign InstructionQ101H = instr_q;

  // ---------------- data port ----------------
  t_dmem_state state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [31:0] rdata_d, rdata_q;
  logic        ready_d, ready_q, fault_d, fault_q;
  logic [31:0] lat_addr_d, lat_addr_q, lat_wdata_d, lat_wdata_q;
  logic [1:0]  lat_size_d, lat_size_q;
  logic        lat_wr_d, lat_wr_q, lat_sext_d, lat_sext_q;

  logic [31:0] a_addr, a_wdata, a_ofs, rd_raw, rd_ext;
  logic [1:0]  a_size, last_ofs;
  logic        a_wr, a_sext, size_err, misalign, in_range, fault;
  logic [32:0] a_first, a_last;
  logic [3:0]  byte_en;
  logic        do_access, mem_we;

  // During WAIT the latched request drives the access; otherwise the live bus.
  always_comb begin
    if (state_q == WAIT) begin
      a_addr = lat_addr_q; a_wdata = lat_wdata_q; a_size = lat_size_q;
      a_wr   = lat_wr_q;   a_sext  = lat_sext_q;
    end else begin
      a_addr = dbus.DAddr; a_wdata = dbus.DWrData; a_size = dbus.DSize;
      a_wr   = dbus.DWrEn; a_sext  = dbus.DSignExt;
    end
    a_first  = {1'b0, a_addr};
    a_last   = a_first + {31'b0, last_ofs};
    in_range = (a_first >= 33'(D_MEM_BASE)) &&
               (a_last < 33'(D_MEM_BASE) + 33'(D_MEM_BYTES));
    fault    = size_err | misalign | ~in_range;
    a_ofs    = a_addr - D_MEM_BASE;
    rd_raw   = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (a_ofs + i < D_MEM_BYTES) rd_raw[8*i +: 8] = dmem[DAW'(a_ofs + i)];
  end

  rvc_mem_wrap_ws_align u_align (
    .size     (a_size),
    .addr_lo  (a_addr[1:0]),
    .sign_ext (a_sext),
    .rd_raw   (rd_raw),
    .byte_en  (byte_en),
    .last_ofs (last_ofs),
    .size_err (size_err),
    .misalign (misalign),
    .rd_ext   (rd_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_size_d  = lat_size_q;
    lat_wr_d    = lat_wr_q;
    lat_sext_d  = lat_sext_q;
    do_access   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (dbus.DReq) begin
          lat_addr_d  = dbus.DAddr;
          lat_wdata_d = dbus.DWrData;
          lat_size_d  = dbus.DSize;
          lat_wr_d    = dbus.DWrEn;
          lat_sext_d  = dbus.DSignExt;
          if (fault) begin
            state_d = RESP;
            ready_d = 1'b1;
            fault_d = 1'b1;
            rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
            ready_d   = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
          ready_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_access && !a_wr) rdata_d = rd_ext;
  end

  assign mem_we = do_access & a_wr & ~Rst;

  always_ff @(posedge Clock) begin
    if (mem_we)
      for (int unsigned i = 0; i < 4; i++)
        if (byte_en[i]) dmem[DAW'(a_ofs + i)] <= a_wdata[8*i +: 8];
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      instr_q     <= RST_INSTR;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_size_q  <= '0;
      lat_wr_q    <= 1'b0;
      lat_sext_q  <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_size_q  <= lat_size_d;
      lat_wr_q    <= lat_wr_d;
      lat_sext_q  <= lat_sext_d;
    end
  end

  assign dbus.DRdData = rdata_q;
  assign dbus.DReady  = ready_q;
  assign dbus.DFault  = fault_q;
  assign dbus.DStall  = (dbus.DReq && state_q != WAIT) || state_q == WAIT;

endmodule

// File: tb/tb_rvc_mem_wrap_ws.sv
// Self-checking bench: three wrapper instances (0, 3 and 5 wait states)
// share one request bus; each scenario looks at the instance it targets.
module tb_rvc_mem_wrap_ws;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en;
  logic        dreq, dwr, dsext;
  logic [1:0]  dsize;
  logic [31:0] daddr, dwdata;

  logic [2:0][31:0] rdata, instr;
  logic [2:0]       ready, fault, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    rvc_mem_wrap_ws_if bus ();
    assign bus.DReq     = dreq;
    assign bus.DWrEn    = dwr;
    assign bus.DSize    = dsize;
    assign bus.DSignExt = dsext;
    assign bus.DAddr    = daddr;
    assign bus.DWrData  = dwdata;
    assign rdata[g]     = bus.DRdData;
    assign ready[g]     = bus.DReady;
    assign fault[g]     = bus.DFault;
    assign stall[g]     = bus.DStall;

    rvc_mem_wrap_ws #(
      .I_MEM_BYTES (4096),
      .D_MEM_BYTES (4096),
      .D_MEM_BASE  (4096),
      .WAIT_STATES (WS),
      .RST_INSTR   (32'h0000_0013)
    ) dut (
      .Clock            (clk),
      .Rst              (rst),
      .Pc               (pc),
      .FetchEn          (fetch_en),
      .InstructionQ101H (instr[g]),
      .dbus             (bus.slave)
    );
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
    dreq = req; dwr = wr; dsize = size; dsext = sext; daddr = addr; dwdata = wdata;
  endtask

  task automatic wait_ready(input int k, input string name);
    int n = 0;
    while (!ready[k] && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(ready[k]), 32'd1);
  endtask

  task automatic do_vec(input vec_t t, input int idx);
    drive(1'b1, t.wr, t.size, t.sext, t.addr, t.wdata);
    #1;
    check($sformatf("v%0d stall_req", idx), 32'(stall[0]), 32'd1);
    tick();
    check($sformatf("v%0d ready", idx), 32'(ready[0]), 32'd1);
    check($sformatf("v%0d fault", idx), 32'(fault[0]), 32'(t.exp_fault));
    if (!t.wr || t.exp_fault)
      check($sformatf("v%0d rdata", idx), rdata[0], t.exp_rd);
    dreq = 1'b0;
    #1;
    check($sformatf("v%0d stall_resp", idx), 32'(stall[0]), 32'd0);
    tick();
    check($sformatf("v%0d ready_low", idx), 32'(ready[0]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; pc = '0; fetch_en = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0);

    g_u[0].dut.imem[0]    = 8'h93; g_u[0].dut.imem[1]    = 8'h00;
    g_u[0].dut.imem[2]    = 8'h50; g_u[0].dut.imem[3]    = 8'h00;
    g_u[0].dut.imem[4]    = 8'h13; g_u[0].dut.imem[5]    = 8'h01;
    g_u[0].dut.imem[6]    = 8'hA0; g_u[0].dut.imem[7]    = 8'h00;
    g_u[0].dut.imem[4092] = 8'h0D; g_u[0].dut.imem[4093] = 8'hF0;
    g_u[0].dut.imem[4094] = 8'hFE; g_u[0].dut.imem[4095] = 8'hCA;

    //        wr    size  sext  addr         wdata          exp_rd         fault
    v.push_back('{1'b1, 2'd2, 1'b0, B,          32'hDEAD_BEEF, 32'h0,         1'b0});
    v.push_back('{1'b0, 2'd2, 1'b0, B,          32'h0,         32'hDEAD_BEEF, 1'b0});
    v.push_back('{1'b1, 2'd0, 1'b0, B + 5,      32'h1234_5680, 32'h0,         1'b0});
    v.push_back('{1'b0, 2'd0, 1'b1, B + 5,      32'h0,         32'hFFFF_FF80, 1'b0});
    v.push_back('{1'b0, 2'd0, 1'b0, B + 5,      32'h0,         32'h0000_0080, 1'b0});
    v.push_back('{1'b1, 2'd1, 1'b0, B + 6,      32'hAAAA_8001, 32'h0,         1'b0});
    v.push_back('{1'b0, 2'd1, 1'b1, B + 6,      32'h0,         32'hFFFF_8001, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b0, B + 6,      32'h0,         32'h0000_8001, 1'b0});
    v.push_back('{1'b1, 2'd2, 1'b0, B + 8,      32'h1122_3344, 32'h0,         1'b0});
    v.push_back('{1'b0, 2'd1, 1'b0, B + 10,     32'h0,         32'h0000_1122, 1'b0});
    v.push_back('{1'b0, 2'd0, 1'b1, B + 11,     32'h0,         32'h0000_0011, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b1, B + 8,      32'h0,         32'h0000_3344, 1'b0});
    v.push_back('{1'b1, 2'd1, 1'b0, B + 1,      32'hFFFF_FFFF, 32'h0,         1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, B + 2,      32'h0,         32'h0,         1'b1});
    v.push_back('{1'b1, 2'd3, 1'b0, B,          32'h0,         32'h0,         1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, B + 4094,   32'h0,         32'h0,         1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, B + 4096,   32'h0,         32'h0,         1'b1});
    v.push_back('{1'b0, 2'd0, 1'b0, B - 1,      32'h0,         32'h0,         1'b1});
    v.push_back('{1'b0, 2'd2, 1'b0, B,          32'h0,         32'hDEAD_BEEF, 1'b0});
    v.push_back('{1'b1, 2'd2, 1'b0, B + 4092,   32'hCAFE_F00D, 32'h0,         1'b0});
    v.push_back('{1'b0, 2'd0, 1'b0, B + 4095,   32'h0,         32'h0000_00CA, 1'b0});
    v.push_back('{1'b0, 2'd1, 1'b1, B + 4094,   32'h0,         32'hFFFF_CAFE, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst instr u%0d", k), instr[k], 32'h0000_0013);
      check($sformatf("rst rdata u%0d", k), rdata[k], 32'h0);
      check($sformatf("rst ready u%0d", k), 32'(ready[k]), 32'd0);
      check($sformatf("rst fault u%0d", k), 32'(fault[k]), 32'd0);
    end
    rst = 1'b0;

    // Fetch path
    pc = 32'd0; fetch_en = 1'b1; tick();
    check("fetch pc0", instr[0], 32'h0050_0093);
    pc = 32'd4; fetch_en = 1'b0; tick();
    check("fetch hold", instr[0], 32'h0050_0093);
    fetch_en = 1'b1; tick();
    check("fetch pc4", instr[0], 32'h00A0_0113);
    pc = 32'd2; tick();
    check("fetch misaligned", instr[0], 32'h0000_0013);
    pc = 32'd4092; tick();
    check("fetch last word", instr[0], 32'hCAFE_F00D);
    pc = 32'd4096; tick();
    check("fetch out of range", instr[0], 32'h0000_0013);
    fetch_en = 1'b0;

    // Single accesses, zero wait states
    foreach (v[i]) do_vec(v[i], i);

    // Back-to-back: store then load of the same word, then another load
    drive(1'b1, 1'b1, 2'd2, 1'b0, B + 12, 32'h5566_7788); tick();
    check("b2b store ready", 32'(ready[0]), 32'd1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, B + 12, 32'h0); #1;
    check("b2b stall in resp", 32'(stall[0]), 32'd1);
    tick();
    check("b2b load1 ready", 32'(ready[0]), 32'd1);
    check("b2b load1 rdata", rdata[0], 32'h5566_7788);
    daddr = B; tick();
    check("b2b load2 ready", 32'(ready[0]), 32'd1);
    check("b2b load2 rdata", rdata[0], 32'hDEAD_BEEF);
    dreq = 1'b0; tick();
    check("b2b idle", 32'(ready[0]), 32'd0);

    // Three wait states on instance 1
    rst = 1'b1; #1; rst = 1'b0;
    drive(1'b1, 1'b1, 2'd2, 1'b0, B + 16, 32'hA5A5_5A5A); tick();
    dreq = 1'b0;
    wait_ready(1, "ws3 store ready");
    tick();
    drive(1'b1, 1'b0, 2'd2, 1'b0, B + 16, 32'h0); #1;
    check("ws3 stall c10", 32'(stall[1]), 32'd1);
    tick();
    for (int c = 11; c <= 13; c++) begin
      drive(1'b1, 1'b0, 2'd2, 1'b0, B + 20, 32'h0); #1;
      check($sformatf("ws3 stall c%0d", c), 32'(stall[1]), 32'd1);
      check($sformatf("ws3 ready c%0d", c), 32'(ready[1]), 32'd0);
      tick();
    end
    dreq = 1'b0; #1;
    check("ws3 ready c14", 32'(ready[1]), 32'd1);
    check("ws3 rdata c14", rdata[1], 32'hA5A5_5A5A);
    check("ws3 stall c14", 32'(stall[1]), 32'd0);
    tick();
    check("ws3 ready c15", 32'(ready[1]), 32'd0);
    drive(1'b1, 1'b0, 2'd1, 1'b0, B + 1, 32'h0); tick();
    check("ws3 fault ready", 32'(ready[1]), 32'd1);
    check("ws3 fault flag", 32'(fault[1]), 32'd1);
    check("ws3 fault rdata", rdata[1], 32'h0);
    dreq = 1'b0; tick();

    // Reset in the middle of a five-wait-state store on instance 2
    rst = 1'b1; #1; rst = 1'b0;
    drive(1'b1, 1'b1, 2'd2, 1'b0, B + 24, 32'h0BAD_F00D); tick();
    dreq = 1'b0;
    wait_ready(2, "ws5 store ready");
    tick();
    drive(1'b1, 1'b0, 2'd2, 1'b0, B + 24, 32'h0); tick();
    dreq = 1'b0;
    wait_ready(2, "ws5 load ready");
    check("ws5 load rdata", rdata[2], 32'h0BAD_F00D);
    tick();
    drive(1'b1, 1'b1, 2'd2, 1'b0, B + 24, 32'h1212_1212); tick();
    dreq = 1'b0; tick();
    check("ws5 stall in wait", 32'(stall[2]), 32'd1);
    rst = 1'b1; #1;
    check("ws5 rst stall", 32'(stall[2]), 32'd0);
    check("ws5 rst ready", 32'(ready[2]), 32'd0);
    check("ws5 rst fault", 32'(fault[2]), 32'd0);
    check("ws5 rst rdata", rdata[2], 32'h0);
    check("ws5 rst instr", instr[0], 32'h0000_0013);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ready[2]) seen = 1'b1;
    end
    check("ws5 no ready after rst", 32'(seen), 32'd0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, B + 24, 32'h0); tick();
    dreq = 1'b0;
    wait_ready(2, "ws5 reload ready");
    check("ws5 word unchanged", rdata[2], 32'h0BAD_F00D);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
